// File: rtl/score_display_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : score_display_scanner_pkg
// Purpose  : Shared definitions for the score display scanner: converter FSM
//            states, 7-segment codes (order a..g, active high), the blank code
//            and the one-hot digit-enable constants.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package score_display_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } fsmState_t;

  // Segment codes, bit order [0:6] = a..g, segment on = 1.
  localparam logic [0:6] c_SEG_0     = 7'b1111110;
  localparam logic [0:6] c_SEG_1     = 7'b0110000;
  localparam logic [0:6] c_SEG_2     = 7'b1101101;
  localparam logic [0:6] c_SEG_3     = 7'b1111001;
  localparam logic [0:6] c_SEG_4     = 7'b0110011;
  localparam logic [0:6] c_SEG_5     = 7'b1011011;
  localparam logic [0:6] c_SEG_6     = 7'b1011111;
  localparam logic [0:6] c_SEG_7     = 7'b1110000;
  localparam logic [0:6] c_SEG_8     = 7'b1111111;
  localparam logic [0:6] c_SEG_9     = 7'b1111011;
  localparam logic [0:6] c_SEG_BLANK = 7'b0000000;

  localparam logic [2:0] c_DIGIT_ONES     = 3'b001;
  localparam logic [2:0] c_DIGIT_TENS     = 3'b010;
  localparam logic [2:0] c_DIGIT_HUNDREDS = 3'b100;

  // Nibbles above 9 never reach the display; they map to blank for safety.
  function automatic logic [0:6] segCode(input logic [3:0] nibble);
    logic [0:6] code;
    case (nibble)
      4'd0:    code = c_SEG_0;
      4'd1:    code = c_SEG_1;
      4'd2:    code = c_SEG_2;
      4'd3:    code = c_SEG_3;
      4'd4:    code = c_SEG_4;
      4'd5:    code = c_SEG_5;
      4'd6:    code = c_SEG_6;
      4'd7:    code = c_SEG_7;
      4'd8:    code = c_SEG_8;
      4'd9:    code = c_SEG_9;
      default: code = c_SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/score_display_scanner_seg7_encode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_encode
// Purpose  : Combinational BCD nibble to 7-segment encoder with blanking.
// Ports    : nibble [3:0] in  - BCD digit 0..9
//            blank        in  - force all segments off
//            seg    [0:6] out - segments a..g, active high
// Revision : 1.0  initial release
// ============================================================================
module seg7_encode
  import score_display_scanner_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [0:6] seg
);

  always_comb begin
    seg = blank ? c_SEG_BLANK : segCode(nibble);
  end

endmodule
`default_nettype wire

// File: rtl/score_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : score_display_scanner
// Purpose  : Converts a binary score to BCD with a bit-serial double-dabble
//            (one bit per clock) and time-multiplexes hundreds/tens/ones onto
//            a single 7-segment bus with one-hot digit enables. Scores above
//            999 saturate the display at 999 and raise overflow.
// Ports    : clk, rst_n (async active-low)
//            point_valid/point/point_ready - score handshake
//            busy      - conversion in progress
//            overflow  - last committed score exceeded 999
//            seg[0:6]  - segments a..g of the enabled digit
//            digit_en  - one-hot: [0]=ones [1]=tens [2]=hundreds
// Config   : BLANK_LEADING_ZERO_EN - blank leading zero hundreds/tens digits
// Revision : 1.0  initial release
// ============================================================================
module score_display_scanner
  import score_display_scanner_pkg::*;
#(
  parameter int POINT_W        = 11,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               point_valid,
  input  logic [POINT_W-1:0] point,
  output logic               point_ready,
  output logic               busy,
  output logic               overflow,
  output logic [0:6]         seg,
  output logic [2:0]         digit_en
);

  localparam int CNT_W = (POINT_W > 1) ? $clog2(POINT_W) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  fsmState_t          r_state;
  fsmState_t          w_nextState;
  logic [POINT_W-1:0] r_shiftReg;
  logic [15:0]        r_bcd;
  logic [15:0]        w_bcdAdj;
  logic               r_bcdCarry;
  logic [CNT_W-1:0]   r_bitCnt;
  logic               w_accept;
  logic               w_isCommit;

  logic [3:0]         r_dispHun;
  logic [3:0]         r_dispTen;
  logic [3:0]         r_dispOne;
  logic               r_overflow;
  logic               w_commitOvf;
  logic [3:0]         w_hunNext;
  logic [3:0]         w_tenNext;
  logic [3:0]         w_oneNext;

  logic [DIV_W-1:0]   r_scanDiv;
  logic               w_scanWrap;
  logic [2:0]         r_digitEn;
  logic [2:0]         w_nextEn;
  logic [3:0]         w_digitNibble;
  logic               w_digitBlank;
  logic [0:6]         w_segCode;
  logic [0:6]         r_seg;

  assign w_accept    = point_valid && (r_state == IDLE);
  assign w_isCommit  = (r_state == COMMIT);
  assign point_ready = (r_state == IDLE);
  assign busy        = ~point_ready;
  assign overflow    = r_overflow;
  assign digit_en    = r_digitEn;

  // --------------------------------------------------------------------------
  // Converter FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = CONVERT;
      CONVERT: if (r_bitCnt == '0) w_nextState = COMMIT;
      COMMIT:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Add-3 correction applied to every nibble before each shift.
  generate
    for (genvar i = 0; i < 4; i++) begin : g_bcdAdj
      assign w_bcdAdj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ?
                                  (r_bcd[4*i +: 4] + 4'd3) : r_bcd[4*i +: 4];
    end
  endgenerate

  // r_bcdCarry catches anything shifted out of the thousands nibble, so wide
  // inputs (>= 10000) still saturate instead of wrapping to a small value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shiftReg <= '0;
      r_bcd      <= '0;
      r_bcdCarry <= 1'b0;
      r_bitCnt   <= '0;
    end else if (w_accept) begin
      r_shiftReg <= point;
      r_bcd      <= '0;
      r_bcdCarry <= 1'b0;
      r_bitCnt   <= CNT_W'(POINT_W - 1);
    end else if (r_state == CONVERT) begin
      r_bcd      <= {w_bcdAdj[14:0], r_shiftReg[POINT_W-1]};
      r_bcdCarry <= r_bcdCarry | w_bcdAdj[15];
      r_shiftReg <= r_shiftReg << 1;
      if (r_bitCnt != '0) begin
        r_bitCnt <= r_bitCnt - CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Display registers: written only in COMMIT so a scan never shows a mix of
  // old and new digits.
  // --------------------------------------------------------------------------
  assign w_commitOvf = (r_bcd[15:12] != 4'd0) || r_bcdCarry;

  always_comb begin
    w_hunNext = r_dispHun;
    w_tenNext = r_dispTen;
    w_oneNext = r_dispOne;
    if (w_isCommit) begin
      w_hunNext = w_commitOvf ? 4'd9 : r_bcd[11:8];
      w_tenNext = w_commitOvf ? 4'd9 : r_bcd[7:4];
      w_oneNext = w_commitOvf ? 4'd9 : r_bcd[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dispHun  <= 4'd0;
      r_dispTen  <= 4'd0;
      r_dispOne  <= 4'd0;
      r_overflow <= 1'b0;
    end else begin
      r_dispHun <= w_hunNext;
      r_dispTen <= w_tenNext;
      r_dispOne <= w_oneNext;
      if (w_isCommit) begin
        r_overflow <= w_commitOvf;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scanner. Segments are computed from the post-edge enable and post-edge
  // display values so seg and digit_en always agree, including when a commit
  // lands on the same edge as a digit change.
  // --------------------------------------------------------------------------
  assign w_scanWrap = (r_scanDiv == DIV_W'(SCAN_DIV - 1));
  assign w_nextEn   = w_scanWrap ? {r_digitEn[1:0], r_digitEn[2]} : r_digitEn;

  always_comb begin
    w_digitNibble = w_oneNext;
    w_digitBlank  = 1'b0;
    case (w_nextEn)
      c_DIGIT_TENS: begin
        w_digitNibble = w_tenNext;
`ifdef BLANK_LEADING_ZERO_EN
        w_digitBlank  = (w_hunNext == 4'd0) && (w_tenNext == 4'd0);
`endif
      end
      c_DIGIT_HUNDREDS: begin
        w_digitNibble = w_hunNext;
`ifdef BLANK_LEADING_ZERO_EN
        w_digitBlank  = (w_hunNext == 4'd0);
`endif
      end
      default: w_digitNibble = w_oneNext;
    endcase
  end

  seg7_encode u_seg7Encode (
    .nibble (w_digitNibble),
    .blank  (w_digitBlank),
    .seg    (w_segCode)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scanDiv <= '0;
      r_digitEn <= c_DIGIT_ONES;
      r_seg     <= c_SEG_0;
    end else begin
      r_scanDiv <= w_scanWrap ? '0 : (r_scanDiv + DIV_W'(1));
      r_digitEn <= w_nextEn;
      r_seg     <= w_segCode;
    end
  end

  generate
    if (SEG_ACTIVE_LOW) begin : g_segActiveLow
      assign seg = ~r_seg;
    end else begin : g_segActiveHigh
      assign seg = r_seg;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_score_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_display_scanner
// Purpose  : Self-checking bench for score_display_scanner. Two instances
//            share stimulus: one with active-high segments and one with
//            active-low segments. Expected segments come from a hand-written
//            code table and an independent scan-position model.
// Config   : honours BLANK_LEADING_ZERO_EN when computing expected segments
// Revision : 1.0  initial release
// ============================================================================
module tb_score_display_scanner;

  localparam int POINT_W  = 11;
  localparam int SCAN_DIV = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               point_valid = 1'b0;
  logic [POINT_W-1:0] point = '0;

  logic               point_ready, busy, overflow;
  logic [0:6]         segHi;
  logic [2:0]         digit_en;
  logic               readyLo, busyLo, overflowLo;
  logic [0:6]         segLo;
  logic [2:0]         digitEnLo;

  int nCompared = 0;
  int nMismatched = 0;

  score_display_scanner #(
    .POINT_W(POINT_W), .SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1'b0)
  ) dutHi (
    .clk(clk), .rst_n(rst_n), .point_valid(point_valid), .point(point),
    .point_ready(point_ready), .busy(busy), .overflow(overflow),
    .seg(segHi), .digit_en(digit_en)
  );

  score_display_scanner #(
    .POINT_W(POINT_W), .SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1'b1)
  ) dutLo (
    .clk(clk), .rst_n(rst_n), .point_valid(point_valid), .point(point),
    .point_ready(readyLo), .busy(busyLo), .overflow(overflowLo),
    .seg(segLo), .digit_en(digitEnLo)
  );

  always #5 clk = ~clk;

  // Scan-position model: each digit is enabled for SCAN_DIV clocks,
  // order ones -> tens -> hundreds, restarting on reset.
  int tbDiv, tbIdx;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbDiv <= 0;
      tbIdx <= 0;
    end else if (tbDiv == SCAN_DIV - 1) begin
      tbDiv <= 0;
      tbIdx <= (tbIdx + 1) % 3;
    end else begin
      tbDiv <= tbDiv + 1;
    end
  end

  int   expH = 0, expT = 0, expO = 0;
  logic expOv = 1'b0;

  typedef struct {
    int score;
    int h;
    int t;
    int o;
    bit ov;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [6:0] codeOf(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] expSeg(input int idx, input int h, input int t, input int o);
    bit blank = 1'b0;
    int d = (idx == 0) ? o : (idx == 1) ? t : h;
`ifdef BLANK_LEADING_ZERO_EN
    if (idx == 2 && h == 0) blank = 1'b1;
    if (idx == 1 && h == 0 && t == 0) blank = 1'b1;
`endif
    return blank ? 7'b0000000 : codeOf(d);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkNow();
    logic [6:0] e;
    logic [6:0] eInv;
    logic [2:0] en;
    e    = expSeg(tbIdx, expH, expT, expO);
    eInv = ~e;
    en   = 3'b001 << tbIdx;
    cmp("digit_en", 32'(digit_en), 32'(en));
    cmp("seg", 32'(segHi), 32'(e));
    cmp("segActiveLow", 32'(segLo), 32'(eInv));
    cmp("overflow", 32'(overflow), 32'(expOv));
  endtask

  task automatic waitAccept();
    int n = 0;
    while (!point_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) cmp("acceptTimeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  // Called just after the accepting edge T. Commit is expected at T+POINT_W+1.
  task automatic convertAndCheck(input int h, input int t, input int o, input bit ov,
                                 input bit hold, input logic [POINT_W-1:0] nextPt);
    @(negedge clk);
    if (hold) point = nextPt;
    else      point_valid = 1'b0;
    cmp("readyDuringConv", 32'(point_ready), 32'd0);
    cmp("busyDuringConv", 32'(busy), 32'd1);
    checkNow();
    repeat (POINT_W) @(posedge clk);
    @(negedge clk);
    cmp("readyBeforeCommit", 32'(point_ready), 32'd0);
    checkNow();
    @(posedge clk);
    expH = h; expT = t; expO = o; expOv = ov;
    @(negedge clk);
    cmp("readyAfterCommit", 32'(point_ready), 32'd1);
    cmp("busyAfterCommit", 32'(busy), 32'd0);
    checkNow();
  endtask

  task automatic scanCheck();
    repeat (3 * SCAN_DIV) begin
      @(negedge clk);
      checkNow();
    end
  endtask

  initial begin
    vecs[0] = '{123,  1, 2, 3, 1'b0};
    vecs[1] = '{1500, 9, 9, 9, 1'b1};
    vecs[2] = '{300,  3, 0, 0, 1'b0};
    vecs[3] = '{2,    0, 0, 2, 1'b0};
    vecs[4] = '{12,   0, 1, 2, 1'b0};
    vecs[5] = '{999,  9, 9, 9, 1'b0};
    vecs[6] = '{1000, 9, 9, 9, 1'b1};
    vecs[7] = '{0,    0, 0, 0, 1'b0};
    vecs[8] = '{2047, 9, 9, 9, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    cmp("resetReady", 32'(point_ready), 32'd1);
    cmp("resetBusy", 32'(busy), 32'd0);
    checkNow();
    rst_n = 1'b1;
    repeat (2 * SCAN_DIV) begin
      @(negedge clk);
      checkNow();
    end

    // Table-driven loads
    for (int i = 0; i < 9; i++) begin
      point       = POINT_W'(vecs[i].score);
      point_valid = 1'b1;
      waitAccept();
      convertAndCheck(vecs[i].h, vecs[i].t, vecs[i].o, vecs[i].ov, 1'b0, '0);
      scanCheck();
    end

    // Producer holds 99 while 100 converts; 99 is taken right after commit.
    @(negedge clk);
    point       = POINT_W'(100);
    point_valid = 1'b1;
    waitAccept();
    convertAndCheck(1, 0, 0, 1'b0, 1'b1, POINT_W'(99));
    waitAccept();
    convertAndCheck(0, 9, 9, 1'b0, 1'b0, '0);
    scanCheck();

    // Reset in the middle of converting 250
    @(negedge clk);
    point       = POINT_W'(250);
    point_valid = 1'b1;
    waitAccept();
    @(negedge clk);
    point_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    expH = 0; expT = 0; expO = 0; expOv = 1'b0;
    cmp("midResetReady", 32'(point_ready), 32'd1);
    cmp("midResetBusy", 32'(busy), 32'd0);
    checkNow();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      checkNow();
    end
    cmp("noCommitAfterReset", 32'(point_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
